// File: rtl/matmul_seq.sv
// Sequencer for C = A x B on NxN row-major 32-bit matrices. It walks the i/j/k loop nest
// over a single-outstanding data-memory port and writes each C element back when its dot product is complete.
module matmul_seq #(
   parameter int          N      = 8,
   parameter logic [31:0] BASE_A = 32'h0000_0100,
   parameter logic [31:0] BASE_B = 32'h0000_0200,
   parameter logic [31:0] BASE_C = 32'h0000_0300
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] cycles
);

   typedef enum logic [2:0] {
      IDLE, RD_A, WAIT_A, RD_B, WAIT_B, MAC, WR_C, DONE
   } state_t;

   localparam logic [31:0] NW   = 32'(N);
   localparam logic [4:0]  LAST = 5'(N - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic [4:0]  r_i;
   logic [4:0]  r_j;
   logic [4:0]  r_k;
   logic [31:0] r_acc;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_cycles;
   logic [31:0] w_off_a;
   logic [31:0] w_off_b;
   logic [31:0] w_off_c;
   logic [31:0] w_prod;

   // Indices only move on state transitions, so the derived addresses stay put during grant stalls.
   assign w_off_a = ((32'(r_i) * NW) + 32'(r_k)) << 2;
   assign w_off_b = ((32'(r_k) * NW) + 32'(r_j)) << 2;
   assign w_off_c = ((32'(r_i) * NW) + 32'(r_j)) << 2;
   assign w_prod  = r_a * r_b;
   assign cycles  = r_cycles;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 32'd0;
      mem_wdata    = 32'd0;
      busy         = (r_state != IDLE);
      done         = (r_state == DONE);
      case (r_state)
         IDLE: begin
            if (start) w_state_next = RD_A;
         end
         RD_A: begin
            mem_req  = 1'b1;
            mem_addr = BASE_A + w_off_a;
            if (mem_gnt) w_state_next = WAIT_A;
         end
         WAIT_A: begin
            if (mem_rvalid) w_state_next = RD_B;
         end
         RD_B: begin
            mem_req  = 1'b1;
            mem_addr = BASE_B + w_off_b;
            if (mem_gnt) w_state_next = WAIT_B;
         end
         WAIT_B: begin
            if (mem_rvalid) w_state_next = MAC;
         end
         MAC: begin
            w_state_next = (r_k == LAST) ? WR_C : RD_A;
         end
         WR_C: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = BASE_C + w_off_c;
            mem_wdata = r_acc;
            if (mem_gnt) begin
               w_state_next = ((r_j == LAST) && (r_i == LAST)) ? DONE : RD_A;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_i      <= 5'd0;
         r_j      <= 5'd0;
         r_k      <= 5'd0;
         r_acc    <= 32'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_cycles <= 32'd0;
      end else begin
         // The loop counter runs through every working state and holds in IDLE and DONE.
         if ((r_state != IDLE) && (r_state != DONE)) begin
            r_cycles <= r_cycles + 32'd1;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_i      <= 5'd0;
                  r_j      <= 5'd0;
                  r_k      <= 5'd0;
                  r_acc    <= 32'd0;
                  r_cycles <= 32'd0;
               end
            end
            WAIT_A: begin
               if (mem_rvalid) r_a <= mem_rdata;
            end
            WAIT_B: begin
               if (mem_rvalid) r_b <= mem_rdata;
            end
            MAC: begin
               r_acc <= r_acc + w_prod;
               if (r_k != LAST) r_k <= r_k + 5'd1;
            end
            WR_C: begin
               if (mem_gnt) begin
                  r_acc <= 32'd0;
                  r_k   <= 5'd0;
                  if (r_j != LAST) begin
                     r_j <= r_j + 5'd1;
                  end else if (r_i != LAST) begin
                     r_j <= 5'd0;
                     r_i <= r_i + 5'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: an N=2 and an N=8 instance, each backed by a small word memory.
// C writes and done/cycles are checked by a monitor against queues filled when each run is set up.
`timescale 1ns/1ps
module tb_matmul_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start2, busy2, done2, req2, we2, gnt2, rvalid2;
   logic [31:0] addr2, wdata2, rdata2, cycles2;
   logic        start8, busy8, done8, req8, we8, gnt8, rvalid8;
   logic [31:0] addr8, wdata8, rdata8, cycles8;

   matmul_seq #(.N(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
      .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
      .mem_gnt(gnt2), .mem_rvalid(rvalid2), .mem_rdata(rdata2), .cycles(cycles2)
   );

   matmul_seq #(.N(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .busy(busy8), .done(done8),
      .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
      .mem_gnt(gnt8), .mem_rvalid(rvalid8), .mem_rdata(rdata8), .cycles(cycles8)
   );

   logic [31:0] mem2 [0:1023];
   logic [31:0] mem8 [0:1023];

   // Ideal read responder: data returns exactly one cycle after an accepted read.
   always @(posedge clk) begin
      rvalid2 <= req2 && gnt2 && !we2;
      rdata2  <= mem2[addr2[11:2]];
      rvalid8 <= req8 && gnt8 && !we8;
      rdata8  <= mem8[addr8[11:2]];
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   logic [63:0] exp_wr2 [$];
   logic [63:0] exp_wr8 [$];
   logic [31:0] exp_cyc2 [$];
   logic [31:0] exp_cyc8 [$];
   logic [63:0] e2, e8;
   int done_cnt2 = 0;
   int done_cnt8 = 0;

   always @(negedge clk) begin
      if (req2 && we2 && gnt2) begin
         $display("dut2 write addr=0x%08h data=0x%08h", addr2, wdata2);
         if (exp_wr2.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_wr2: got addr 0x%08h required no write", addr2);
         end else begin
            e2 = exp_wr2.pop_front();
            check("c_addr2", addr2, e2[63:32]);
            check("c_data2", wdata2, e2[31:0]);
         end
      end
      if (req8 && we8 && gnt8) begin
         $display("dut8 write addr=0x%08h data=0x%08h", addr8, wdata8);
         if (exp_wr8.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_wr8: got addr 0x%08h required no write", addr8);
         end else begin
            e8 = exp_wr8.pop_front();
            check("c_addr8", addr8, e8[63:32]);
            check("c_data8", wdata8, e8[31:0]);
         end
      end
      if (done2) begin
         done_cnt2++;
         $display("dut2 done cycles=%0d", cycles2);
         if (exp_cyc2.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done2: got cycles %0d required no done", cycles2);
         end else check("cycles2", cycles2, exp_cyc2.pop_front());
      end
      if (done8) begin
         done_cnt8++;
         $display("dut8 done cycles=%0d", cycles8);
         if (exp_cyc8.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done8: got cycles %0d required no done", cycles8);
         end else check("cycles8", cycles8, exp_cyc8.pop_front());
      end
   end

   task automatic load2(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
      mem2[64] = a0; mem2[65] = a1; mem2[66] = a2; mem2[67] = a3;
      mem2[128] = b0; mem2[129] = b1; mem2[130] = b2; mem2[131] = b3;
   endtask

   task automatic expect2(input logic [31:0] c0, c1, c2, c3, cyc);
      exp_wr2.push_back({32'h300, c0});
      exp_wr2.push_back({32'h304, c1});
      exp_wr2.push_back({32'h308, c2});
      exp_wr2.push_back({32'h30C, c3});
      exp_cyc2.push_back(cyc);
   endtask

   task automatic pulse2();
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
   endtask

   // Waits for done on the N=2 instance, then checks busy at done and one cycle later.
   task automatic wait_done2(input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (done2) seen = 1'b1;
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL %s_timeout: got no done required done within %0d cycles", name, budget);
      end else begin
         check({name, "_busy_at_done"}, 32'(busy2), 32'd1);
         @(negedge clk);
         check({name, "_busy_after"}, 32'(busy2), 32'd0);
      end
   endtask

   int d0;

   initial begin
      reset = 1'b1; start2 = 1'b0; start8 = 1'b0; gnt2 = 1'b1; gnt8 = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy2), 32'd0);
      check("rst_done", 32'(done2), 32'd0);
      check("rst_req", 32'(req2), 32'd0);
      check("rst_cycles", cycles2, 32'd0);
      check("rst_busy8", 32'(busy8), 32'd0);

      // N=2 basic: A x I = A
      load2(1, 2, 3, 4, 1, 0, 0, 1);
      expect2(1, 2, 3, 4, 44);
      d0 = done_cnt2;
      pulse2();
      wait_done2(200, "basic");
      check("basic_done_once", 32'(done_cnt2 - d0), 32'd1);

      // N=8: A[i][j]=i+j+1, B=I
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            mem8[64 + i*8 + j]  = 32'(i + j + 1);
            mem8[128 + i*8 + j] = (i == j) ? 32'd1 : 32'd0;
            exp_wr8.push_back({32'h300 + 32'(4*(i*8 + j)), 32'(i + j + 1)});
         end
      end
      exp_cyc8.push_back(32'd2624);
      d0 = done_cnt8;
      @(negedge clk); start8 = 1'b1;
      @(negedge clk); start8 = 1'b0;
      for (int n = 0; n < 3000 && done_cnt8 == d0; n++) @(negedge clk);
      check("n8_done_once", 32'(done_cnt8 - d0), 32'd1);
      @(negedge clk);
      check("n8_busy_after", 32'(busy8), 32'd0);

      // N=2 with a three-cycle grant stall on the first A read
      load2(1, 2, 3, 4, 1, 0, 0, 1);
      expect2(1, 2, 3, 4, 47);
      gnt2 = 1'b0;
      pulse2();
      for (int s = 0; s < 4; s++) begin
         if (s > 0) @(negedge clk);
         check("stall_req", 32'(req2), 32'd1);
         check("stall_addr", addr2, 32'h100);
      end
      gnt2 = 1'b1;
      wait_done2(200, "stall");

      // N=2 wrap: 0xFFFFFFFF*1 + 2*1 = 1 mod 2^32; row1 = 5+6 = 11
      load2(32'hFFFF_FFFF, 2, 5, 6, 1, 1, 1, 1);
      expect2(1, 1, 11, 11, 44);
      pulse2();
      wait_done2(200, "wrap");

      // start re-pulsed mid-run must be ignored
      load2(1, 2, 3, 4, 1, 0, 0, 1);
      expect2(1, 2, 3, 4, 44);
      d0 = done_cnt2;
      pulse2();
      repeat (5) @(negedge clk);
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      repeat (10) @(negedge clk);
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      wait_done2(200, "repulse");
      repeat (3) @(negedge clk);
      check("repulse_done_once", 32'(done_cnt2 - d0), 32'd1);

      // A fresh start after done begins a new run with the counter cleared
      expect2(1, 2, 3, 4, 44);
      pulse2();
      check("restart_cycles0", cycles2, 32'd0);
      wait_done2(200, "restart");

      // Reset during WAIT_B (fourth cycle after acceptance) aborts at once
      pulse2();
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 32'(busy2), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_req", 32'(req2), 32'd0);
      check("abort_busy", 32'(busy2), 32'd0);
      check("abort_done", 32'(done2), 32'd0);
      check("abort_cycles", cycles2, 32'd0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy2), 32'd0);
      expect2(1, 2, 3, 4, 44);
      pulse2();
      wait_done2(200, "after_rst");

      repeat (3) @(negedge clk);
      check("sb_wr2_empty", 32'(exp_wr2.size()), 32'd0);
      check("sb_wr8_empty", 32'(exp_wr8.size()), 32'd0);
      check("sb_cyc2_empty", 32'(exp_cyc2.size()), 32'd0);
      check("sb_cyc8_empty", 32'(exp_cyc8.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
